// File: rtl/mmio_ctrl_pkg.sv
// Shared MMIO address map, register-select encoding and decode helper.
package mmio_ctrl_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned CNT_W  = 32;
  localparam int unsigned BYTE_W = 8;

  localparam logic [ADDR_W-1:0] MMIO_STATUS = 32'h8000_0000;
  localparam logic [ADDR_W-1:0] MMIO_RXDATA = 32'h8000_0004;
  localparam logic [ADDR_W-1:0] MMIO_TXDATA = 32'h8000_0008;
  localparam logic [ADDR_W-1:0] MMIO_CYCLE  = 32'h8000_0010;
  localparam logic [ADDR_W-1:0] MMIO_INST   = 32'h8000_0014;
  localparam logic [ADDR_W-1:0] MMIO_CLR    = 32'h8000_0018;

  typedef enum logic [2:0] {
    SEL_NONE,
    SEL_STATUS,
    SEL_RXDATA,
    SEL_TXDATA,
    SEL_CYCLE,
    SEL_INST,
    SEL_CLR
  } mmio_sel_e;

  // Qualified access presented to the register block in one cycle.
  typedef struct packed {
    logic      ld;
    logic      st;
    mmio_sel_e sel;
  } mmio_req_t;

  // Exact-match address decode; anything outside the map selects nothing.
  function automatic mmio_sel_e mmio_decode(input logic [ADDR_W-1:0] addr);
    mmio_sel_e sel;
    sel = SEL_NONE;
    case (addr)
      MMIO_STATUS: sel = SEL_STATUS;
      MMIO_RXDATA: sel = SEL_RXDATA;
      MMIO_TXDATA: sel = SEL_TXDATA;
      MMIO_CYCLE:  sel = SEL_CYCLE;
      MMIO_INST:   sel = SEL_INST;
      MMIO_CLR:    sel = SEL_CLR;
      default:     sel = SEL_NONE;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/mmio_ctrl_sync_fifo.sv
// Synchronous FIFO; push is dropped when full (full judged before any pop).
module mmio_ctrl_sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_rdata_c,
  output logic             o_full_c,
  output logic             o_empty_c
);

  localparam int unsigned PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned FILL_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0]  r_mem [DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [FILL_W-1:0] r_count;
  logic              w_do_push;
  logic              w_do_pop;

  assign o_full_c  = (r_count == FILL_W'(DEPTH));
  assign o_empty_c = (r_count == '0);
  assign w_do_push = i_push && !o_full_c;
  assign w_do_pop  = i_pop && !o_empty_c;
  assign o_rdata_c = r_mem[r_rd_ptr];

  // Pointers and fill count; pointers wrap naturally at a power-of-2 depth.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + FILL_W'(1);
        2'b01:   r_count <= r_count - FILL_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage needs no reset: the empty flag hides stale entries.
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_wdata;
  end

endmodule

// File: rtl/mmio_ctrl.sv
// MMIO controller: address decode, UART TX FIFO / RX holding register,
// cycle and retired-instruction counters, registered load data.
module mmio_ctrl
  import mmio_ctrl_pkg::*;
#(
  parameter int unsigned W_SIZE   = 32,
  parameter int unsigned TX_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [W_SIZE-1:0] io_addr,
  input  logic              io_ld,
  input  logic              io_st,
  input  logic [7:0]        io_wdata,
  input  logic              stall,
  input  logic              inst_retire,
  output logic [W_SIZE-1:0] io_rdata,
  output logic              uart_tx_valid,
  output logic [7:0]        uart_tx_data,
  input  logic              uart_tx_ready,
  input  logic              uart_rx_valid,
  input  logic [7:0]        uart_rx_data,
  output logic              uart_rx_ready
);

  mmio_req_t         w_req;
  logic              w_tx_push;
  logic              w_tx_full;
  logic              w_tx_empty;
  logic              w_rx_capture;
  logic              w_rx_pop;
  logic              w_cnt_clr;
  logic [W_SIZE-1:0] w_rdata_nxt;

  logic [W_SIZE-1:0] r_rdata;
  logic              r_rx_full;
  logic [BYTE_W-1:0] r_rx_byte;
  logic [CNT_W-1:0]  r_cycle_cnt;
  logic [CNT_W-1:0]  r_inst_cnt;

  // Qualify the X/M access against stall and decode its target register.
  always_comb begin
    w_req     = '0;
    w_req.ld  = io_ld && !stall;
    w_req.st  = io_st && !stall;
    w_req.sel = mmio_decode(ADDR_W'(io_addr));
  end

  assign w_tx_push    = w_req.st && (w_req.sel == SEL_TXDATA);
  assign w_cnt_clr    = w_req.st && (w_req.sel == SEL_CLR);
  assign w_rx_pop     = w_req.ld && (w_req.sel == SEL_RXDATA) && r_rx_full;
  assign w_rx_capture = uart_rx_valid && !r_rx_full;

  assign uart_tx_valid = !w_tx_empty;
  assign uart_rx_ready = !r_rx_full;
  assign io_rdata      = r_rdata;

  mmio_ctrl_sync_fifo #(
    .WIDTH (BYTE_W),
    .DEPTH (TX_DEPTH)
  ) u_tx_fifo (
    .clk       (clk),
    .rst       (rst),
    .i_push    (w_tx_push),
    .i_wdata   (io_wdata),
    .i_pop     (uart_tx_ready),
    .o_rdata_c (uart_tx_data),
    .o_full_c  (w_tx_full),
    .o_empty_c (w_tx_empty)
  );

  // Read mux; values are the pre-update register contents.
  always_comb begin
    w_rdata_nxt = '0;
    case (w_req.sel)
      SEL_STATUS: w_rdata_nxt = W_SIZE'({r_rx_full, !w_tx_full});
      SEL_RXDATA: w_rdata_nxt = W_SIZE'(r_rx_full ? r_rx_byte : 8'h00);
      SEL_CYCLE:  w_rdata_nxt = W_SIZE'(r_cycle_cnt);
      SEL_INST:   w_rdata_nxt = W_SIZE'(r_inst_cnt);
      default:    w_rdata_nxt = '0;
    endcase
  end

  // Load data register: updates only on a qualified load, otherwise holds.
  always_ff @(posedge clk) begin
    if (rst)           r_rdata <= '0;
    else if (w_req.ld) r_rdata <= w_rdata_nxt;
  end

  // One-entry RX holding register; capture and pop are mutually exclusive.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rx_full <= 1'b0;
      r_rx_byte <= '0;
    end else if (w_rx_capture) begin
      r_rx_full <= 1'b1;
      r_rx_byte <= uart_rx_data;
    end else if (w_rx_pop) begin
      r_rx_full <= 1'b0;
    end
  end

  // Free-running counters; a clear store wins over the same-cycle increment.
  always_ff @(posedge clk) begin
    if (rst || w_cnt_clr) begin
      r_cycle_cnt <= '0;
      r_inst_cnt  <= '0;
    end else begin
      r_cycle_cnt <= r_cycle_cnt + CNT_W'(1);
      if (inst_retire) r_inst_cnt <= r_inst_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_mmio_ctrl.sv
// Directed self-checking bench for mmio_ctrl.
module tb_mmio_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] io_addr;
  logic        io_ld;
  logic        io_st;
  logic [7:0]  io_wdata;
  logic        stall;
  logic        inst_retire;
  logic [31:0] io_rdata;
  logic        uart_tx_valid;
  logic [7:0]  uart_tx_data;
  logic        uart_tx_ready;
  logic        uart_rx_valid;
  logic [7:0]  uart_rx_data;
  logic        uart_rx_ready;

  int n_checks = 0;
  int n_pass   = 0;

  localparam logic [31:0] A_STATUS = 32'h8000_0000;
  localparam logic [31:0] A_RX     = 32'h8000_0004;
  localparam logic [31:0] A_TX     = 32'h8000_0008;
  localparam logic [31:0] A_CYCLE  = 32'h8000_0010;
  localparam logic [31:0] A_INST   = 32'h8000_0014;
  localparam logic [31:0] A_CLR    = 32'h8000_0018;

  mmio_ctrl #(.W_SIZE(32), .TX_DEPTH(4)) dut (
    .clk           (clk),
    .rst           (rst),
    .io_addr       (io_addr),
    .io_ld         (io_ld),
    .io_st         (io_st),
    .io_wdata      (io_wdata),
    .stall         (stall),
    .inst_retire   (inst_retire),
    .io_rdata      (io_rdata),
    .uart_tx_valid (uart_tx_valid),
    .uart_tx_data  (uart_tx_data),
    .uart_tx_ready (uart_tx_ready),
    .uart_rx_valid (uart_rx_valid),
    .uart_rx_data  (uart_rx_data),
    .uart_rx_ready (uart_rx_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input logic [31:0] addr);
    io_addr = addr;
    io_ld   = 1'b1;
    tick();
    io_ld   = 1'b0;
    io_addr = '0;
  endtask

  task automatic do_store(input logic [31:0] addr, input logic [7:0] data);
    io_addr  = addr;
    io_wdata = data;
    io_st    = 1'b1;
    tick();
    io_st    = 1'b0;
    io_addr  = '0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; io_addr = '0; io_ld = 1'b0; io_st = 1'b0; io_wdata = '0;
    stall = 1'b0; inst_retire = 1'b0; uart_tx_ready = 1'b0;
    uart_rx_valid = 1'b0; uart_rx_data = '0;
    tick(); tick();
    rst = 1'b0;

    // 1: reset state, idle counting, status, unmapped address
    chk("rst_rdata", io_rdata, 32'h0);
    chk("rst_tx_valid", 32'(uart_tx_valid), 32'h0);
    chk("rst_rx_ready", 32'(uart_rx_ready), 32'h1);
    repeat (10) tick();
    do_load(A_CYCLE);
    chk("idle_cycle_cnt", io_rdata, 32'd10);
    do_load(A_INST);
    chk("idle_inst_cnt", io_rdata, 32'd0);
    do_load(A_STATUS);
    chk("status_idle", io_rdata, 32'h1);
    do_load(32'h8000_0001);
    chk("unmapped_load", io_rdata, 32'h0);

    // 2: overfill TX FIFO while transmitter is busy, then drain
    for (int i = 0; i < 5; i++) do_store(A_TX, 8'(8'h41 + i));
    do_load(A_STATUS);
    chk("status_tx_full", io_rdata, 32'h0);
    uart_tx_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("drain_valid", 32'(uart_tx_valid), 32'h1);
      chk("drain_data", 32'(uart_tx_data), 32'h41 + 32'(i));
      tick();
    end
    chk("drain_empty", 32'(uart_tx_valid), 32'h0);
    uart_tx_ready = 1'b0;

    // 3: push while full in the same cycle as a pop is dropped
    for (int i = 0; i < 4; i++) do_store(A_TX, 8'(8'h61 + i));
    uart_tx_ready = 1'b1;
    do_store(A_TX, 8'h55);
    for (int i = 0; i < 3; i++) begin
      chk("fullpop_data", 32'(uart_tx_data), 32'h62 + 32'(i));
      tick();
    end
    chk("fullpop_empty", 32'(uart_tx_valid), 32'h0);
    uart_tx_ready = 1'b0;

    // 4: RX capture, blocked second byte, pop, empty pop
    uart_rx_valid = 1'b1; uart_rx_data = 8'h5A;
    tick();
    uart_rx_data = 8'h77;
    chk("rx_ready_low", 32'(uart_rx_ready), 32'h0);
    tick();
    uart_rx_valid = 1'b0;
    do_load(A_STATUS);
    chk("status_rx_full", io_rdata, 32'h3);
    do_load(A_RX);
    chk("rx_byte", io_rdata, 32'h5A);
    chk("rx_ready_high", 32'(uart_rx_ready), 32'h1);
    do_load(A_RX);
    chk("rx_empty_load", io_rdata, 32'h0);

    // 5: instruction counting and clear-beats-increment
    do_store(A_CLR, 8'h00);
    inst_retire = 1'b1;
    repeat (7) tick();
    do_load(A_INST);
    chk("inst_cnt_7", io_rdata, 32'd7);
    do_store(A_CLR, 8'hFF);
    do_load(A_INST);
    chk("inst_after_clr", io_rdata, 32'd0);
    do_load(A_CYCLE);
    chk("cycle_after_clr", io_rdata, 32'd1);
    do_load(A_INST);
    chk("inst_resume", io_rdata, 32'd2);
    inst_retire = 1'b0;

    // 6: cycle counter wrap
    force dut.r_cycle_cnt = 32'hFFFF_FFFE;
    #1;
    release dut.r_cycle_cnt;
    do_load(A_CYCLE);
    chk("wrap_fffe", io_rdata, 32'hFFFF_FFFE);
    do_load(A_CYCLE);
    chk("wrap_ffff", io_rdata, 32'hFFFF_FFFF);
    do_load(A_CYCLE);
    chk("wrap_zero", io_rdata, 32'h0);

    // stalled accesses have no effect
    stall = 1'b1;
    do_load(A_STATUS);
    chk("stall_load_hold", io_rdata, 32'h0);
    do_store(A_TX, 8'h99);
    chk("stall_store_drop", 32'(uart_tx_valid), 32'h0);
    stall = 1'b0;

    // reset with queued TX bytes
    do_store(A_TX, 8'hA1);
    do_store(A_TX, 8'hA2);
    chk("queued_valid", 32'(uart_tx_valid), 32'h1);
    do_load(A_STATUS);
    chk("queued_status", io_rdata, 32'h1);
    rst = 1'b1;
    tick();
    chk("midrst_tx_valid", 32'(uart_tx_valid), 32'h0);
    chk("midrst_rdata", io_rdata, 32'h0);
    rst = 1'b0;
    tick();
    chk("postrst_tx_valid", 32'(uart_tx_valid), 32'h0);
    chk("postrst_rx_ready", 32'(uart_rx_ready), 32'h1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
